// File: rtl/stream_demux_pkg.sv
// Shared sizing helpers and default parameters for the stream demultiplexer.
package stream_demux_pkg;

    function automatic int unsigned clog2_f(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((r < 32) && ((32'd1 << r) < n)) begin
            r = r + 1;
        end
        return r;
    endfunction

    // A one-channel demux still needs a 1-bit tag so the port exists.
    function automatic int unsigned dest_w_for(input int unsigned n);
        return (n <= 1) ? 1 : clog2_f(n);
    endfunction

    function automatic int unsigned sat_max(input int unsigned w);
        return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    endfunction

    localparam int unsigned DEF_DATA_W  = 8;
    localparam int unsigned DEF_NUM_OUT = 3;
    localparam int unsigned DEF_DEST_W  = dest_w_for(DEF_NUM_OUT);
    localparam int unsigned DEF_CNT_W   = 8;

endpackage

// File: rtl/stream_demux_if.sv
// Bundle of the input stream, per-channel output streams and drop status.
import stream_demux_pkg::*;

interface stream_demux_if #(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int NUM_OUT = DEF_NUM_OUT,
    parameter int DEST_W  = DEF_DEST_W,
    parameter int CNT_W   = DEF_CNT_W
) ();
    logic               in_valid;
    logic               in_ready;
    logic [DATA_W-1:0]  in_data;
    logic [DEST_W-1:0]  in_dest;
    logic [NUM_OUT-1:0] out_valid;
    logic [NUM_OUT-1:0] out_ready;
    logic [DATA_W-1:0]  out_data;
    logic [CNT_W-1:0]   drop_cnt;
    logic               drop_pulse;

    modport slave (
        input  in_valid, in_data, in_dest, out_ready,
        output in_ready, out_valid, out_data, drop_cnt, drop_pulse
    );

    modport master (
        output in_valid, in_data, in_dest, out_ready,
        input  in_ready, out_valid, out_data, drop_cnt, drop_pulse
    );
endinterface

// File: rtl/stream_reg_slice.sv
// Single-entry valid/ready register slice; full throughput when the sink drains every cycle.
import stream_demux_pkg::*;

module stream_reg_slice #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         s_valid_i,
    output logic         s_ready_o,
    input  logic [W-1:0] s_data_i,
    output logic         m_valid_o,
    input  logic         m_ready_i,
    output logic [W-1:0] m_data_o
);
    logic         full_q, full_d;
    logic [W-1:0] data_q, data_d;
    logic         load;

    // Accept while empty, or while the held entry leaves in the same cycle.
    assign s_ready_o = !full_q || m_ready_i;
    assign load      = s_valid_i && s_ready_o;

    always_comb begin
        full_d = load || (full_q && !m_ready_i);
        data_d = load ? s_data_i : data_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign m_valid_o = full_q;
    assign m_data_o  = data_q;
endmodule

// File: rtl/stream_demux.sv
// Registered 1-to-N stream demultiplexer with out-of-range drop counting.
import stream_demux_pkg::*;

module stream_demux #(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int NUM_OUT = DEF_NUM_OUT,
    parameter int DEST_W  = DEF_DEST_W,
    parameter int CNT_W   = DEF_CNT_W
) (
    input logic            clk,
    input logic            rst,
    stream_demux_if.slave  bus
);
    localparam int PW = DEST_W + DATA_W;
    localparam logic [DEST_W:0]  NUM_OUT_L = (DEST_W + 1)'(NUM_OUT);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(sat_max(CNT_W));

    logic               dest_ok;
    logic               in_ready;
    logic               full;
    logic               drain;
    logic               drop;
    logic [PW-1:0]      payload;
    logic [DEST_W-1:0]  dest_q;
    logic [DATA_W-1:0]  data_q;
    logic [NUM_OUT-1:0] sel;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               pulse_q, pulse_d;

    assign dest_ok = {1'b0, bus.in_dest} < NUM_OUT_L;

    // Only in-range beats enter the slot; out-of-range ones share in_ready but vanish.
    stream_reg_slice #(
        .W (PW)
    ) u_slot (
        .clk       (clk),
        .rst       (rst),
        .s_valid_i (bus.in_valid && dest_ok),
        .s_ready_o (in_ready),
        .s_data_i  ({bus.in_dest, bus.in_data}),
        .m_valid_o (full),
        .m_ready_i (drain),
        .m_data_o  (payload)
    );

    assign {dest_q, data_q} = payload;

    for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_sel
        assign sel[gi] = full && (dest_q == DEST_W'(gi));
    end

    // Masking with sel makes the ready of unselected channels irrelevant.
    assign drain = |(sel & bus.out_ready);
    assign drop  = bus.in_valid && in_ready && !dest_ok;

    always_comb begin
        cnt_d   = cnt_q;
        pulse_d = drop;
        if (drop && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = sel;
    assign bus.out_data   = data_q;
    assign bus.drop_cnt   = cnt_q;
    assign bus.drop_pulse = pulse_q;
endmodule

// File: tb/tb_stream_demux.sv
// Scoreboard bench for stream_demux; a second instance with a 2-bit counter checks saturation.
import stream_demux_pkg::*;

module tb_stream_demux;
    localparam int DATA_W  = 8;
    localparam int NUM_OUT = 3;
    localparam int DEST_W  = 2;
    localparam int CNT_W   = 8;
    localparam int CNT_W2  = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    stream_demux_if #(.DATA_W(DATA_W), .NUM_OUT(NUM_OUT), .DEST_W(DEST_W), .CNT_W(CNT_W))  bus ();
    stream_demux_if #(.DATA_W(DATA_W), .NUM_OUT(NUM_OUT), .DEST_W(DEST_W), .CNT_W(CNT_W2)) bus2 ();

    assign bus2.in_valid  = bus.in_valid;
    assign bus2.in_data   = bus.in_data;
    assign bus2.in_dest   = bus.in_dest;
    assign bus2.out_ready = bus.out_ready;

    stream_demux #(.DATA_W(DATA_W), .NUM_OUT(NUM_OUT), .DEST_W(DEST_W), .CNT_W(CNT_W)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    stream_demux #(.DATA_W(DATA_W), .NUM_OUT(NUM_OUT), .DEST_W(DEST_W), .CNT_W(CNT_W2)) u_dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    typedef struct {
        int          ch;
        logic [7:0]  data;
    } beat_t;

    beat_t      sb[$];
    int         n_vec = 0;
    int         n_err = 0;
    int         exp_cnt, exp_cnt2;
    logic       exp_pulse;
    logic [7:0] last_data;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        exp_cnt   = 0;
        exp_cnt2  = 0;
        exp_pulse = 1'b0;
        last_data = 8'h00;
    endtask

    // Called mid-cycle: compare outputs, then predict what the next rising edge does.
    task automatic check_cycle();
        logic [2:0] ov_exp;
        logic       rdy_exp;
        beat_t      b;
        ov_exp  = (sb.size() != 0) ? (3'b001 << sb[0].ch) : 3'b000;
        rdy_exp = (sb.size() == 0) || bus.out_ready[sb[0].ch];
        chk("out_valid",   {29'd0, bus.out_valid}, {29'd0, ov_exp});
        chk("out_data",    {24'd0, bus.out_data}, {24'd0, last_data});
        chk("in_ready",    {31'd0, bus.in_ready}, {31'd0, rdy_exp});
        chk("drop_cnt",    {24'd0, bus.drop_cnt}, exp_cnt);
        chk("drop_pulse",  {31'd0, bus.drop_pulse}, {31'd0, exp_pulse});
        chk("drop_cnt_w2", {30'd0, bus2.drop_cnt}, exp_cnt2);
        chk("out_valid_2", {29'd0, bus2.out_valid}, {29'd0, ov_exp});

        exp_pulse = 1'b0;
        if ((sb.size() != 0) && bus.out_ready[sb[0].ch]) begin
            b = sb.pop_front();
            $display("deliver ch=%0d data=%02h", b.ch, b.data);
        end
        if (bus.in_valid && rdy_exp) begin
            if (int'(bus.in_dest) < NUM_OUT) begin
                b.ch   = int'(bus.in_dest);
                b.data = bus.in_data;
                sb.push_back(b);
                last_data = bus.in_data;
                $display("accept dest=%0d data=%02h", bus.in_dest, bus.in_data);
            end else begin
                exp_pulse = 1'b1;
                if (exp_cnt != 255) exp_cnt++;
                if (exp_cnt2 != 3) exp_cnt2++;
                $display("drop dest=%0d data=%02h", bus.in_dest, bus.in_data);
            end
        end
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic [1:0] dst, input logic [2:0] rdy);
        @(posedge clk);
        #1;
        bus.in_valid  = v;
        bus.in_data   = v ? d : 8'($urandom);
        bus.in_dest   = v ? dst : 2'($urandom);
        bus.out_ready = rdy;
        @(negedge clk);
        check_cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.in_dest   = 2'd0;
        bus.out_ready = 3'b111;
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        chk("rst_out_valid",  {29'd0, bus.out_valid}, 32'd0);
        chk("rst_out_data",   {24'd0, bus.out_data}, 32'd0);
        chk("rst_drop_cnt",   {24'd0, bus.drop_cnt}, 32'd0);
        chk("rst_drop_pulse", {31'd0, bus.drop_pulse}, 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;

        // single beat
        step(1'b1, 8'h3C, 2'd2, 3'b111);
        step(1'b0, 8'h00, 2'd0, 3'b111);
        step(1'b0, 8'h00, 2'd0, 3'b111);

        // streaming across all channels
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 8'h10 + 8'(i), 2'(i % 3), 3'b111);
        end
        step(1'b0, 8'h00, 2'd0, 3'b111);
        step(1'b0, 8'h00, 2'd0, 3'b111);

        // backpressure on channel 1 with a beat for channel 0 waiting
        step(1'b1, 8'h51, 2'd1, 3'b101);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 8'h60, 2'd0, 3'b101);
        end
        step(1'b1, 8'h60, 2'd0, 3'b111);
        step(1'b0, 8'h00, 2'd0, 3'b111);
        step(1'b0, 8'h00, 2'd0, 3'b111);

        // out-of-range destination: two drops, then three more to saturate the 2-bit counter
        step(1'b1, 8'h77, 2'd3, 3'b111);
        step(1'b1, 8'h78, 2'd3, 3'b111);
        step(1'b0, 8'h00, 2'd0, 3'b111);
        step(1'b0, 8'h00, 2'd0, 3'b111);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 8'h80 + 8'(i), 2'd3, 3'b111);
        end
        step(1'b0, 8'h00, 2'd0, 3'b111);
        step(1'b0, 8'h00, 2'd0, 3'b111);

        // drain of a held beat coinciding with a dropped beat
        step(1'b1, 8'h88, 2'd0, 3'b111);
        step(1'b1, 8'h99, 2'd3, 3'b111);
        step(1'b0, 8'h00, 2'd0, 3'b111);
        step(1'b0, 8'h00, 2'd0, 3'b111);

        // asynchronous reset while a stalled beat is held
        step(1'b1, 8'hA5, 2'd1, 3'b101);
        step(1'b0, 8'h00, 2'd0, 3'b101);
        @(posedge clk);
        #3;
        bus.in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", {29'd0, bus.out_valid}, 32'd0);
        chk("arst_drop_cnt",  {24'd0, bus.drop_cnt}, 32'd0);
        chk("arst_out_data",  {24'd0, bus.out_data}, 32'd0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b0;
        @(negedge clk);
        check_cycle();
        step(1'b0, 8'h00, 2'd0, 3'b111);
        step(1'b0, 8'h00, 2'd0, 3'b111);

        // traffic still flows after reset
        step(1'b1, 8'hC3, 2'd1, 3'b111);
        step(1'b0, 8'h00, 2'd0, 3'b111);
        step(1'b0, 8'h00, 2'd0, 3'b111);
        chk("sb_empty_end", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
